// File: rtl/pipe_pkg.sv
// Shared decode vocabulary for the five-stage MIPS pipeline controller:
// instruction kinds, Tuse/Tnew constants, forward-select codes, field macros.
`define OP(i)    (i[31:26])
`define RS(i)    (i[25:21])
`define RT(i)    (i[20:16])
`define RD(i)    (i[15:11])
`define SHAMT(i) (i[10:6])
`define FUNCT(i) (i[5:0])

package pipe_pkg;

  typedef enum logic [3:0] {
    K_NOP,
    K_ADDU,
    K_SUBU,
    K_LUI,
    K_ORI,
    K_LW,
    K_SW,
    K_BEQ,
    K_MULTU,
    K_MFLO,
    K_UNKNOWN
  } kind_e;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2b;

  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam logic [1:0] TUSE_0  = 2'd0;
  localparam logic [1:0] TUSE_1  = 2'd1;
  localparam logic [1:0] TUSE_2  = 2'd2;
  localparam logic [1:0] TUSE_NA = 2'd3;

  localparam logic [1:0] TNEW_0   = 2'd0;
  localparam logic [1:0] TNEW_ALU = 2'd1;
  localparam logic [1:0] TNEW_LW  = 2'd2;

  localparam logic [1:0] FM_NONE = 2'd0;
  localparam logic [1:0] FM_M    = 2'd1;
  localparam logic [1:0] FM_W    = 2'd2;

  function automatic logic [1:0] tnew_dec(input logic [1:0] t);
    return (t == TNEW_0) ? TNEW_0 : t - 2'd1;
  endfunction

  // Youngest producer wins; a not-yet-ready M producer blocks W.
  function automatic logic [1:0] fwd_sel(
    input logic       uses,
    input logic [4:0] src,
    input logic [4:0] m_dst,
    input logic [1:0] m_tnew,
    input logic [4:0] w_dst
  );
    logic [1:0] sel;
    sel = FM_NONE;
    if (uses && src != 5'd0) begin
      if (src == m_dst)
        sel = (m_tnew == TNEW_0) ? FM_M : FM_NONE;
      else if (src == w_dst)
        sel = FM_W;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_decode.sv
// Per-stage instruction classifier: kind, destination register,
// operand use times and result-ready time for the hazard unit.
module hazard_decode
  import pipe_pkg::*;
(
  input  logic [31:0] instr,
  output kind_e       kind,
  output logic [4:0]  dest,
  output logic [1:0]  rs_tuse,
  output logic [1:0]  rt_tuse,
  output logic [1:0]  tnew_e,
  output logic        uses_rs,
  output logic        uses_rt,
  output logic        is_md
);

  logic [5:0] op;
  logic [5:0] fn;
  logic [4:0] rt;
  logic [4:0] rd;
  logic       sp;
  logic       nop;

  assign op  = `OP(instr);
  assign fn  = `FUNCT(instr);
  assign rt  = `RT(instr);
  assign rd  = `RD(instr);
  assign sp  = (op == OP_SPECIAL);
  assign nop = (instr == 32'd0);

  always_comb begin
    kind    = K_UNKNOWN;
    dest    = 5'd0;
    rs_tuse = TUSE_NA;
    rt_tuse = TUSE_NA;
    tnew_e  = TNEW_0;
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    is_md   = 1'b0;
    unique case (1'b1)
      nop: kind = K_NOP;
      sp && fn == FN_ADDU: begin
        kind    = K_ADDU;
        dest    = rd;
        uses_rs = 1'b1;
        uses_rt = 1'b1;
        rs_tuse = TUSE_1;
        rt_tuse = TUSE_1;
        tnew_e  = TNEW_ALU;
      end
      sp && fn == FN_SUBU: begin
        kind    = K_SUBU;
        dest    = rd;
        uses_rs = 1'b1;
        uses_rt = 1'b1;
        rs_tuse = TUSE_1;
        rt_tuse = TUSE_1;
        tnew_e  = TNEW_ALU;
      end
      sp && fn == FN_MULTU: begin
        kind    = K_MULTU;
        uses_rs = 1'b1;
        uses_rt = 1'b1;
        rs_tuse = TUSE_1;
        rt_tuse = TUSE_1;
        is_md   = 1'b1;
      end
      sp && fn == FN_MFLO: begin
        kind   = K_MFLO;
        dest   = rd;
        tnew_e = TNEW_ALU;
        is_md  = 1'b1;
      end
      op == OP_LUI: begin
        kind   = K_LUI;
        dest   = rt;
        tnew_e = TNEW_ALU;
      end
      op == OP_ORI: begin
        kind    = K_ORI;
        dest    = rt;
        uses_rs = 1'b1;
        rs_tuse = TUSE_1;
        tnew_e  = TNEW_ALU;
      end
      op == OP_LW: begin
        kind    = K_LW;
        dest    = rt;
        uses_rs = 1'b1;
        rs_tuse = TUSE_1;
        tnew_e  = TNEW_LW;
      end
      op == OP_SW: begin
        kind    = K_SW;
        uses_rs = 1'b1;
        uses_rt = 1'b1;
        rs_tuse = TUSE_1;
        rt_tuse = TUSE_2;
      end
      op == OP_BEQ: begin
        kind    = K_BEQ;
        uses_rs = 1'b1;
        uses_rt = 1'b1;
        rs_tuse = TUSE_0;
        rt_tuse = TUSE_0;
      end
      default: kind = K_UNKNOWN;
    endcase
  end

endmodule

// File: rtl/hazard_pipe_ctrl.sv
// D/E/M/W instruction pipe with Tuse/Tnew stall detection,
// forwarding selects and multiplier busy tracking.
module hazard_pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int DELAY_SLOT = 1,
  parameter int MD_CYCLES  = 5,
  parameter int FWD_ENABLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] f_instr,
  input  logic        d_branch_taken,
  output logic        pc_enable,
  output logic        d_pff_enable,
  output logic        stall,
  output logic [31:0] d_instr,
  output logic [31:0] e_instr,
  output logic [31:0] m_instr,
  output logic [31:0] w_instr,
  output logic [1:0]  fm_d1,
  output logic [1:0]  fm_d2,
  output logic [1:0]  fm_e1,
  output logic [1:0]  fm_e2,
  output logic        fm_m2,
  output logic        md_busy
);

  localparam int CW = $clog2(MD_CYCLES + 1);
  localparam logic [CW-1:0] MD_LOAD = CW'(MD_CYCLES);
  localparam int ST_D = 0;
  localparam int ST_E = 1;
  localparam int ST_M = 2;
  localparam int ST_W = 3;

  logic [31:0]   d_q, d_d, e_q, e_d;
  logic [31:0]   m_q, m_d, w_q, w_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [31:0] stg     [4];
  kind_e       kind    [4];
  logic [4:0]  dest    [4];
  logic [1:0]  rs_tuse [4];
  logic [1:0]  rt_tuse [4];
  logic [1:0]  tnew_e  [4];
  logic [1:0]  tnew    [4];
  logic        uses_rs [4];
  logic        uses_rt [4];
  logic        is_md   [4];

  logic data_stall;
  logic md_stall;
  logic unused_dec;

  assign stg[ST_D] = d_q;
  assign stg[ST_E] = e_q;
  assign stg[ST_M] = m_q;
  assign stg[ST_W] = w_q;

  for (genvar s = 0; s < 4; s++) begin : g_dec
    hazard_decode u_dec (
      .instr   (stg[s]),
      .kind    (kind[s]),
      .dest    (dest[s]),
      .rs_tuse (rs_tuse[s]),
      .rt_tuse (rt_tuse[s]),
      .tnew_e  (tnew_e[s]),
      .uses_rs (uses_rs[s]),
      .uses_rt (uses_rt[s]),
      .is_md   (is_md[s])
    );
  end

  assign tnew[ST_D] = tnew_e[ST_D];
  assign tnew[ST_E] = tnew_e[ST_E];
  assign tnew[ST_M] = tnew_dec(tnew_e[ST_M]);
  assign tnew[ST_W] = TNEW_0;

  // Without forwarding every in-flight producer blocks its consumer.
  always_comb begin
    data_stall = 1'b0;
    for (int s = ST_E; s <= ST_W; s++) begin
      if (dest[s] != 5'd0) begin
        if (uses_rs[ST_D] && `RS(d_q) == dest[s] &&
            (FWD_ENABLE == 0 || rs_tuse[ST_D] < tnew[s]))
          data_stall = 1'b1;
        if (uses_rt[ST_D] && `RT(d_q) == dest[s] &&
            (FWD_ENABLE == 0 || rt_tuse[ST_D] < tnew[s]))
          data_stall = 1'b1;
      end
    end
  end

  assign md_busy      = (cnt_q != '0) || (kind[ST_E] == K_MULTU);
  assign md_stall     = is_md[ST_D] && md_busy;
  assign stall        = data_stall || md_stall;
  assign pc_enable    = ~stall;
  assign d_pff_enable = ~stall;

  always_comb begin
    fm_d1 = FM_NONE;
    fm_d2 = FM_NONE;
    fm_e1 = FM_NONE;
    fm_e2 = FM_NONE;
    fm_m2 = 1'b0;
    if (FWD_ENABLE != 0) begin
      fm_d1 = fwd_sel(uses_rs[ST_D], `RS(d_q),
                      dest[ST_M], tnew[ST_M], dest[ST_W]);
      fm_d2 = fwd_sel(uses_rt[ST_D], `RT(d_q),
                      dest[ST_M], tnew[ST_M], dest[ST_W]);
      fm_e1 = fwd_sel(uses_rs[ST_E], `RS(e_q),
                      dest[ST_M], tnew[ST_M], dest[ST_W]);
      fm_e2 = fwd_sel(uses_rt[ST_E], `RT(e_q),
                      dest[ST_M], tnew[ST_M], dest[ST_W]);
      fm_m2 = (kind[ST_M] == K_SW) && (`RT(m_q) != 5'd0) &&
              (`RT(m_q) == dest[ST_W]);
    end
  end

  always_comb begin
    d_d = d_q;
    e_d = d_q;
    m_d = e_q;
    w_d = m_q;
    if (stall)
      e_d = 32'd0;
    else if (DELAY_SLOT == 0 && d_branch_taken)
      d_d = 32'd0;
    else
      d_d = f_instr;
  end

  // A MULTU leaving E always advances, so it loads even on a stall edge.
  always_comb begin
    cnt_d = cnt_q;
    if (kind[ST_E] == K_MULTU)
      cnt_d = MD_LOAD;
    else if (cnt_q != '0)
      cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q   <= 32'd0;
      e_q   <= 32'd0;
      m_q   <= 32'd0;
      w_q   <= 32'd0;
      cnt_q <= '0;
    end else begin
      d_q   <= d_d;
      e_q   <= e_d;
      m_q   <= m_d;
      w_q   <= w_d;
      cnt_q <= cnt_d;
    end
  end

  assign d_instr = d_q;
  assign e_instr = e_q;
  assign m_instr = m_q;
  assign w_instr = w_q;

  always_comb begin
    unused_dec = 1'b0;
    for (int s = 0; s < 4; s++)
      unused_dec = unused_dec ^ (^{kind[s], dest[s], rs_tuse[s],
                   rt_tuse[s], tnew_e[s], tnew[s], uses_rs[s],
                   uses_rt[s], is_md[s]});
  end

endmodule

// File: tb/tb_hazard_pipe_ctrl.sv
// Directed checks of hazard_pipe_ctrl: default build plus a build with
// DELAY_SLOT=0, FWD_ENABLE=0, MD_CYCLES=3.
module tb_hazard_pipe_ctrl;

  localparam logic [31:0] I_NOP   = 32'h0000_0000;
  localparam logic [31:0] I_LW1   = 32'h8C01_0000;
  localparam logic [31:0] I_LW4   = 32'h8C04_0000;
  localparam logic [31:0] I_ADDU2 = 32'h0023_1021;
  localparam logic [31:0] I_ADDU1 = 32'h0043_0821;
  localparam logic [31:0] I_ORI4  = 32'h3404_0005;
  localparam logic [31:0] I_ORI5  = 32'h3405_0007;
  localparam logic [31:0] I_ORI9  = 32'h3409_0009;
  localparam logic [31:0] I_BEQ   = 32'h1080_0001;
  localparam logic [31:0] I_SW5   = 32'hAC05_0000;
  localparam logic [31:0] I_MULTU = 32'h00C7_0019;
  localparam logic [31:0] I_MFLO  = 32'h0000_4012;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] f_main, f_alt;
  logic        br_main, br_alt;

  logic        m_pc, m_pff, m_stall, m_fm2, m_busy;
  logic [31:0] m_d, m_e, m_m, m_w;
  logic [1:0]  m_fd1, m_fd2, m_fe1, m_fe2;

  logic        a_pc, a_pff, a_stall, a_fm2, a_busy;
  logic [31:0] a_d, a_e, a_m, a_w;
  logic [1:0]  a_fd1, a_fd2, a_fe1, a_fe2;

  int errors = 0;
  int checks = 0;
  int n;

  always #5 clk = ~clk;

  hazard_pipe_ctrl u_main (
    .clk(clk), .rst_n(rst_n), .f_instr(f_main),
    .d_branch_taken(br_main), .pc_enable(m_pc),
    .d_pff_enable(m_pff), .stall(m_stall),
    .d_instr(m_d), .e_instr(m_e), .m_instr(m_m), .w_instr(m_w),
    .fm_d1(m_fd1), .fm_d2(m_fd2), .fm_e1(m_fe1), .fm_e2(m_fe2),
    .fm_m2(m_fm2), .md_busy(m_busy)
  );

  hazard_pipe_ctrl #(
    .DELAY_SLOT(0), .MD_CYCLES(3), .FWD_ENABLE(0)
  ) u_alt (
    .clk(clk), .rst_n(rst_n), .f_instr(f_alt),
    .d_branch_taken(br_alt), .pc_enable(a_pc),
    .d_pff_enable(a_pff), .stall(a_stall),
    .d_instr(a_d), .e_instr(a_e), .m_instr(a_m), .w_instr(a_w),
    .fm_d1(a_fd1), .fm_d2(a_fd2), .fm_e1(a_fe1), .fm_e2(a_fe2),
    .fm_m2(a_fm2), .md_busy(a_busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    f_main = I_NOP; f_alt = I_NOP;
    br_main = 1'b0; br_alt = 1'b0;
    tick; tick;
    chk("rst_d", m_d, 0);
    chk("rst_w", m_w, 0);
    chk("rst_pc", m_pc, 1);
    chk("rst_pff", m_pff, 1);
    chk("rst_stall", m_stall, 0);
    chk("rst_busy", m_busy, 0);
    chk("rst_fm", {m_fd1, m_fd2, m_fe1, m_fe2, m_fm2}, 0);
    chk("rst_alt_pc", a_pc, 1);
    rst_n = 1'b1;

    // busy window then asynchronous reset mid-multiply
    f_main = I_MULTU; tick;
    f_main = I_NOP; tick;
    chk("busy_e", m_busy, 1);
    tick;
    chk("busy_cnt", m_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_e", m_e, 0);
    chk("arst_m", m_m, 0);
    chk("arst_busy", m_busy, 0);
    chk("arst_pc", m_pc, 1);
    f_main = I_ORI4; tick;
    chk("arst_hold_d", m_d, 0);
    rst_n = 1'b1;

    // load-use
    f_main = I_LW1; tick;
    chk("lu_nostall0", m_stall, 0);
    f_main = I_ADDU2; tick;
    chk("lu_stall", m_stall, 1);
    chk("lu_pc", m_pc, 0);
    f_main = I_NOP; tick;
    chk("lu_bubble", m_e, 0);
    chk("lu_hold_d", m_d, I_ADDU2);
    chk("lu_release", m_stall, 0);
    tick;
    chk("lu_e", m_e, I_ADDU2);
    chk("lu_fm_e1", m_fe1, 2);
    chk("lu_fm_e2", m_fe2, 0);

    // ori -> beq: one stall then forward from M
    f_main = I_ORI4; tick;
    f_main = I_BEQ; tick;
    chk("ob_stall", m_stall, 1);
    f_main = I_NOP; tick;
    chk("ob_release", m_stall, 0);
    chk("ob_fm_d1", m_fd1, 1);
    chk("ob_fm_d2", m_fd2, 0);
    br_main = 1'b1; f_main = I_ORI9; tick;
    chk("ds1_keep", m_d, I_ORI9);
    br_main = 1'b0;

    // lw -> beq: two stalls then forward from W
    f_main = I_LW4; tick;
    f_main = I_BEQ; tick;
    chk("lb_stall1", m_stall, 1);
    f_main = I_NOP; tick;
    chk("lb_stall2", m_stall, 1);
    chk("lb_fm_d1_m", m_fd1, 0);
    tick;
    chk("lb_release", m_stall, 0);
    chk("lb_fm_d1_w", m_fd1, 2);
    tick;

    // store data
    f_main = I_ORI5; tick;
    f_main = I_SW5; tick;
    chk("st_nostall", m_stall, 0);
    f_main = I_NOP; tick;
    chk("st_nostall_e", m_stall, 0);
    chk("st_fm_e1", m_fe1, 0);
    chk("st_fm_e2", m_fe2, 1);
    tick;
    chk("st_fm_m2", m_fm2, 1);

    // multu -> mflo, MD_CYCLES=5
    f_main = I_MULTU; tick;
    chk("md_nostall", m_stall, 0);
    f_main = I_MFLO; tick;
    chk("md_stall0", m_stall, 1);
    n = 1;
    f_main = I_NOP;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (m_stall) n++;
      else break;
    end
    chk("md_stalls", n, 6);
    chk("md_busy_end", m_busy, 0);
    chk("md_d", m_d, I_MFLO);

    // alternate build: branch squash without delay slot
    f_alt = I_BEQ; tick;
    br_alt = 1'b1; f_alt = I_ORI4; tick;
    chk("sq_d", a_d, 0);
    chk("sq_e", a_e, I_BEQ);
    br_alt = 1'b0;

    // alternate build: no forwarding
    f_alt = I_ADDU1; tick;
    f_alt = I_ADDU2; tick;
    chk("nf_stall", a_stall, 1);
    chk("nf_fm0", {a_fd1, a_fd2, a_fe1, a_fe2, a_fm2}, 0);
    n = 1;
    br_alt = 1'b1; f_alt = I_NOP; tick;
    chk("nf_br_ignored", a_d, I_ADDU2);
    chk("nf_fm_m", {a_fd1, a_fd2, a_fe1, a_fe2, a_fm2}, 0);
    if (a_stall) n++;
    br_alt = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (a_stall) n++;
      else break;
    end
    chk("nf_stalls", n, 3);

    // alternate build: MD_CYCLES=3
    f_alt = I_MULTU; tick;
    f_alt = I_MFLO; tick;
    chk("md3_stall0", a_stall, 1);
    n = 1;
    f_alt = I_NOP;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (a_stall) n++;
      else break;
    end
    chk("md3_stalls", n, 4);
    chk("md3_busy_end", a_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_pipe_ctrl.md
# hazard_pipe_ctrl

Parametrised pipeline controller for the five-stage MIPS core. It carries the instruction word through the D/E/M/W stages and detects data hazards with a Tuse/Tnew scheme. It drives stall, flush and forwarding-mux selects, and tracks an iterative multiplier's busy window. It sits beside the datapath and replaces the fixed, stall-only control block.

## Interface
Parameters:
- DELAY_SLOT, 1: 1 = branch delay slot; 0 = a taken branch squashes the instruction entering D.
- MD_CYCLES, 5: multiplier latency in cycles, legal range 1..15.
- FWD_ENABLE, 1: 0 = no forwarding; every data hazard is resolved by stalling.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- f_instr  in  32  fetched instruction, captured into D.
- d_branch_taken  in  1  branch in D resolved taken (datapath comparator).
- pc_enable  out  1  PC write enable.
- d_pff_enable  out  1  F/D register enable.
- stall  out  1  hazard stall this cycle.
- d_instr, e_instr, m_instr, w_instr  out  32 each  per-stage instruction registers.
- fm_d1, fm_d2  out  2 each  D-stage rs/rt forward select (branch compare).
- fm_e1, fm_e2  out  2 each  E-stage ALU operand forward select.
- fm_m2  out  1  M-stage store-data select: 1 = W write data.
- md_busy  out  1  multiplier busy.

## Operation
- Decode of each stage word:
  - Kinds: ADDU, SUBU, LUI, ORI, LW, SW, BEQ, MULTU, MFLO, NOP. Anything else is UNKNOWN and is treated as NOP.
  - Dest: rd for ADDU/SUBU/MFLO; rt for LUI/ORI/LW; none otherwise.
  - Dest 0 never creates a hazard.
- Tuse:
  - BEQ: rs 0, rt 0.
  - ADDU/SUBU/MULTU: rs 1, rt 1.
  - ORI/LW: rs 1.
  - SW: rs 1, rt 2.
- Tnew in E: LW 2; all other producers 1. In M: max(TnewE-1, 0). In W: 0.
- Stall (FWD_ENABLE=1): for each source of D, stall if it matches the dest of E or M and Tuse < Tnew of that producer.
- MD stall: also stall when D holds MULTU or MFLO while md_busy=1.
- Stall (FWD_ENABLE=0): stall on any dest match in E, M or W; all fm_* are held at 0.
- Forward selects, 0 = register-file/pipe value:
  - fm_d*: 1 = M result, 2 = W data.
  - fm_e*: 1 = M result, 2 = W data.
  - fm_m2: 1 = W data.
  - The youngest match wins (M beats W).
  - A source that matches a producer with Tnew > 0 still selects 0; stall covers that case.
- Multiplier:
  - A MULTU in E at a clock edge loads counter = MD_CYCLES.
  - Otherwise a nonzero counter decrements by 1 per cycle.
  - md_busy = (counter != 0) | (E holds MULTU).

## Timing
- Reset: all stage registers hold 0 (NOP), counter = 0.
- Outputs during reset: stall 0, pc_enable 1, d_pff_enable 1, all fm_* 0, md_busy 0.
- stall and fm_* are combinational from the stage registers.
- pc_enable = d_pff_enable = ~stall.
- Normal edge: D<=f_instr, E<=D, M<=E, W<=M.
- Stall edge: D holds, E<=0 (bubble), M and W advance.
- Branch squash: if DELAY_SLOT=0, d_branch_taken=1 and stall=0, then D<=0 at the edge.
- d_branch_taken is ignored while stall=1; the branch re-resolves once its operands are ready.
- Stall and MULTU in E at the same edge: the counter still loads, because the MULTU advances.
- Counter wrap-around is not possible: it saturates at 0.
- rst_n asserted mid-stall or mid-multiply clears all state on the same cycle, without waiting for a clock edge.

## Structure
- Shared package pipe_pkg holds:
  - kind codes;
  - Tuse/Tnew constants;
  - forward-select encodings (FM_NONE=0, FM_M=1, FM_W=2);
  - field macros OP/RS/RT/RD/SHAMT/FUNCT.
- One sub-module, hazard_decode: combinational. Takes instr[31:0] and produces kind, dest, rs_tuse, rt_tuse, tnew_e, uses_rs, uses_rt, is_md. It is instantiated once per stage (D, E, M, W).
- Counter width is derived from MD_CYCLES (4 bits at max).

## Test plan
- Reset check: hold rst_n=0 mid-stream, then release. Required response:
  - all stage registers 0;
  - pc_enable=1, stall=0, md_busy=0.
- Load-use: lw $1,0($0) then addu $2,$1,$3. Required response:
  - exactly 1 stall cycle with e_instr=0;
  - then fm_e1=2 when addu is in E.
- Branch hazard:
  - ori $4,$0,5 then beq $4,$0: 1 stall, then fm_d1=1 (forward from M).
  - lw $4 then beq $4: 2 stalls.
- Store data: ori $5 then sw $5,0($0) back-to-back. Required response: no stall; fm_e1=0; fm_m2=1.
- Multiplier (MD_CYCLES=5): multu then mflo. Required response: mflo held in D with stall for 6 cycles, then md_busy=0.
- Parameter modes:
  - DELAY_SLOT=0 with d_branch_taken=1: d_instr=0 at the next cycle.
  - FWD_ENABLE=0 with addu $1 then addu $2,$1: 3 stall cycles and all fm_*=0.
